// File: rtl/gate_sched_pkg.sv
// Shared types and constants for the gate scheduler.
// Optional statistics are enabled by defining GATE_SCHED_STATS_EN.
package gate_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_NL   = 3'd1,
        ST_FETCH     = 3'd2,
        ST_OFFER     = 3'd3,
        ST_CYCLE_END = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // Truth-table code of an XOR gate (free-XOR, no ciphertexts needed).
    localparam logic [3:0] XOR_CODE = 4'b0110;

    localparam int STAT_W = 32;

endpackage

// File: rtl/gate_sched_if.sv
// Bus between the garbling control / netlist store / engine and the scheduler.
// The master side is the environment; the scheduler uses the slave modport.
// Statistic signals exist only when GATE_SCHED_STATS_EN is defined.
interface gate_sched_if
    import gate_sched_pkg::*;
#(
    parameter int S = 14,
    parameter int C = 16
);
    logic         start;
    logic [C-1:0] num_cycles;
    logic         nl_done;
    logic [S-1:0] gate_size;
    logic [3:0]   g_logic;
    logic [S-1:0] rd_addr;
    logic         prep_next_cycle;
    logic         g_valid;
    logic         g_ready;
    logic [C-1:0] cycle_idx;
    logic         busy;
    logic         finished;
`ifdef GATE_SCHED_STATS_EN
    logic [STAT_W-1:0] xor_cnt;
    logic [STAT_W-1:0] nonxor_cnt;

    modport master (
        output start, num_cycles, nl_done, gate_size, g_logic, g_ready,
        input  rd_addr, prep_next_cycle, g_valid, cycle_idx, busy, finished,
        input  xor_cnt, nonxor_cnt
    );
    modport slave (
        input  start, num_cycles, nl_done, gate_size, g_logic, g_ready,
        output rd_addr, prep_next_cycle, g_valid, cycle_idx, busy, finished,
        output xor_cnt, nonxor_cnt
    );
`else
    modport master (
        output start, num_cycles, nl_done, gate_size, g_logic, g_ready,
        input  rd_addr, prep_next_cycle, g_valid, cycle_idx, busy, finished
    );
    modport slave (
        input  start, num_cycles, nl_done, gate_size, g_logic, g_ready,
        output rd_addr, prep_next_cycle, g_valid, cycle_idx, busy, finished
    );
`endif
endinterface

// File: rtl/gate_scheduler_sat_counter.sv
// Width-parameterised saturating counter with synchronous clear and enable.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    // Count up on enable, stick at all-ones, clear on reset or clr.
    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (en && (q != '1))
            q <= q + W'(1);
    end

endmodule

// File: rtl/gate_scheduler.sv
// Gate scheduler: walks rd_addr over every gate of each garbled cycle,
// offers each descriptor to the engine through valid/ready, pulses
// prep_next_cycle at the end of each cycle and finished at session end.
// Define GATE_SCHED_STATS_EN to add xor_cnt / nonxor_cnt statistics.
module gate_scheduler
    import gate_sched_pkg::*;
#(
    parameter int S = 14,
    parameter int C = 16
) (
    input  logic        clk,
    input  logic        rst,
    gate_sched_if.slave bus
);

    state_t       state_q, state_d;
    logic [S-1:0] rd_addr_q, rd_addr_d;
    logic [S-1:0] gate_size_q, gate_size_d;
    logic [C-1:0] cycle_idx_q, cycle_idx_d;
    logic [C-1:0] num_cyc_q, num_cyc_d;
    logic         start_acc;
    logic         accept;
    logic         last_gate;
    logic         last_cycle;

    assign start_acc  = (state_q == ST_IDLE) && bus.start;
    assign accept     = (state_q == ST_OFFER) && bus.g_ready;
    // gate_size_q is never 0 in OFFER and num_cyc_q never 0 in CYCLE_END,
    // so the -1 cannot wrap where these are used.
    assign last_gate  = (rd_addr_q == gate_size_q - S'(1));
    assign last_cycle = (cycle_idx_q == num_cyc_q - C'(1));

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            gate_size_q <= '0;
            cycle_idx_q <= '0;
            num_cyc_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            gate_size_q <= gate_size_d;
            cycle_idx_q <= cycle_idx_d;
            num_cyc_q   <= num_cyc_d;
        end
    end

    // Next-state and next-datapath decode.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        gate_size_d = gate_size_q;
        cycle_idx_d = cycle_idx_q;
        num_cyc_d   = num_cyc_q;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    num_cyc_d   = bus.num_cycles;
                    cycle_idx_d = '0;
                    state_d     = ST_WAIT_NL;
                end
            end
            ST_WAIT_NL: begin
                // Zero-cycle session is decided on the latched count.
                if (num_cyc_q == '0) begin
                    state_d = ST_DONE;
                end else if (bus.nl_done) begin
                    gate_size_d = bus.gate_size;
                    rd_addr_d   = '0;
                    state_d     = (bus.gate_size != '0) ? ST_FETCH : ST_CYCLE_END;
                end
            end
            ST_FETCH: begin
                state_d = ST_OFFER;
            end
            ST_OFFER: begin
                if (accept) begin
                    if (last_gate) begin
                        state_d = ST_CYCLE_END;
                    end else begin
                        rd_addr_d = rd_addr_q + S'(1);
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_CYCLE_END: begin
                if (last_cycle) begin
                    state_d = ST_DONE;
                end else begin
                    cycle_idx_d = cycle_idx_q + C'(1);
                    state_d     = ST_WAIT_NL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.rd_addr         = rd_addr_q;
    assign bus.cycle_idx       = cycle_idx_q;
    assign bus.g_valid         = (state_q == ST_OFFER);
    assign bus.prep_next_cycle = (state_q == ST_CYCLE_END);
    assign bus.finished        = (state_q == ST_DONE);
    assign bus.busy            = (state_q != ST_IDLE);

`ifdef GATE_SCHED_STATS_EN
    logic is_xor;
    assign is_xor = (bus.g_logic == XOR_CODE);

    sat_counter #(.W(STAT_W)) u_xor_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .en  (accept && is_xor),
        .q   (bus.xor_cnt)
    );

    sat_counter #(.W(STAT_W)) u_nonxor_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .en  (accept && !is_xor),
        .q   (bus.nonxor_cnt)
    );
`else
    logic unused_g_logic;
    assign unused_g_logic = ^bus.g_logic;
`endif

endmodule

// File: tb/tb_gate_scheduler.sv
// Scoreboard bench for gate_scheduler: each scenario pushes the expected
// accepted (cycle_idx, rd_addr) pairs, a monitor records real handshakes,
// and the scenario compares them plus pulse counts and latencies.
module tb_gate_scheduler;
    localparam int S = 14;
    localparam int C = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gate_sched_if #(.S(S), .C(C)) bus ();

    gate_scheduler #(.S(S), .C(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int valid_cnt = 0;
    int prep_cnt = 0;
    int fin_cnt = 0;
    int viol_cnt = 0;
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    int obs_ptr = 0;
    logic [3:0] code_tbl[16];

    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic         prst = 1'b1;
    logic [S-1:0] pa = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record handshakes and count pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.g_valid) valid_cnt <= valid_cnt + 1;
        if (bus.prep_next_cycle) prep_cnt <= prep_cnt + 1;
        if (bus.finished) fin_cnt <= fin_cnt + 1;
        if (bus.g_valid && bus.g_ready)
            obs_q.push_back({bus.cycle_idx, 2'b00, bus.rd_addr});
        if (pv && !pr && !prst && (!bus.g_valid || bus.rd_addr != pa))
            viol_cnt <= viol_cnt + 1;
        pv   <= bus.g_valid;
        pr   <= bus.g_ready;
        pa   <= bus.rd_addr;
        prst <= rst;
    end

    function automatic logic [31:0] enc(input int c, input int a);
        logic [31:0] cv, av;
        cv = c;
        av = a;
        return {cv[15:0], 2'b00, av[13:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one session acting as control, netlist store and engine.
    task automatic run_session(input int ncyc, input int gsz, input int stall_gate,
                               input int stall_len, input int rst_cycle, input int rst_gate,
                               output int t_start, output int t_nl, output int t_prep,
                               output int t_fin, output bit timed_out);
        int stall_left;
        bit nl_next;
        stall_left = stall_len;
        nl_next    = 1'b1;
        t_nl = -1; t_prep = -1; t_fin = -1; timed_out = 1'b1;
        bus.num_cycles = C'(ncyc);
        bus.gate_size  = S'(gsz);
        bus.g_ready    = 1'b1;
        bus.start      = 1'b1;
        t_start        = cyc;
        step();
        bus.start = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (bus.finished) begin
                t_fin = cyc;
                timed_out = 1'b0;
                bus.nl_done = 1'b0;
                return;
            end
            bus.nl_done = nl_next;
            if (nl_next) t_nl = cyc;
            nl_next = 1'b0;
            if (bus.prep_next_cycle) begin
                t_prep  = cyc;
                nl_next = 1'b1;
            end
            bus.g_logic = code_tbl[bus.rd_addr[3:0]];
            if (rst_cycle >= 0 && bus.g_valid && int'(bus.cycle_idx) == rst_cycle &&
                int'(bus.rd_addr) == rst_gate) begin
                rst = 1'b1;
                bus.g_ready = 1'b0;
                bus.nl_done = 1'b0;
                step();
                rst = 1'b0;
                bus.g_ready = 1'b1;
                timed_out = 1'b0;
                return;
            end
            if (bus.g_valid && int'(bus.rd_addr) == stall_gate && stall_left > 0) begin
                bus.g_ready = 1'b0;
                stall_left--;
            end else begin
                bus.g_ready = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.num_cycles = C'(1);
        step(); step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.g_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.g_valid); end
        checks++; if (bus.prep_next_cycle !== 1'b0) begin errors++; $display("FAIL rst_prep: got %b want 0", bus.prep_next_cycle); end
        checks++; if (bus.finished !== 1'b0) begin errors++; $display("FAIL rst_finished: got %b want 0", bus.finished); end
        checks++; if (bus.rd_addr !== '0) begin errors++; $display("FAIL rst_rd_addr: got %0d want 0", bus.rd_addr); end
        checks++; if (bus.cycle_idx !== '0) begin errors++; $display("FAIL rst_cycle_idx: got %0d want 0", bus.cycle_idx); end
`ifdef GATE_SCHED_STATS_EN
        checks++; if (bus.xor_cnt !== '0 || bus.nonxor_cnt !== '0) begin errors++;
            $display("FAIL rst_stats: got %0d/%0d want 0/0", bus.xor_cnt, bus.nonxor_cnt); end
`endif
        bus.start = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_cycle();
        int ts, tn, tp, tf, v0, p0;
        bit to;
        logic [31:0] e;
        v0 = valid_cnt; p0 = prep_cnt;
        for (int a = 0; a < 3; a++) exp_q.push_back(enc(0, a));
        run_session(1, 3, -1, 0, -1, -1, ts, tn, tp, tf, to);
        checks++; if (to) begin errors++; $display("FAIL single_timeout: got timeout want finished"); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_ptr >= obs_q.size()) begin errors++; $display("FAIL single_gate: got none want %h", e); end
            else begin
                if (obs_q[obs_ptr] !== e) begin errors++; $display("FAIL single_gate: got %h want %h", obs_q[obs_ptr], e); end
                obs_ptr++;
            end
        end
        checks++; if (obs_ptr != obs_q.size()) begin errors++; $display("FAIL single_extra: got %0d extra want 0", obs_q.size() - obs_ptr); obs_ptr = obs_q.size(); end
        checks++; if (tf - tn != 8) begin errors++; $display("FAIL single_latency: got %0d want 8", tf - tn); end
        checks++; if (tf - tp != 1) begin errors++; $display("FAIL single_prep_to_fin: got %0d want 1", tf - tp); end
        checks++; if (prep_cnt - p0 != 1) begin errors++; $display("FAIL single_prep_cnt: got %0d want 1", prep_cnt - p0); end
        checks++; if (valid_cnt - v0 != 3) begin errors++; $display("FAIL single_valid_cycles: got %0d want 3", valid_cnt - v0); end
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy %b want 0", bus.busy); end
    endtask

    task automatic test_backpressure();
        int ts, tn, tp, tf, v0, x0;
        bit to;
        logic [31:0] e;
        v0 = valid_cnt; x0 = viol_cnt;
        for (int a = 0; a < 3; a++) exp_q.push_back(enc(0, a));
        run_session(1, 3, 1, 5, -1, -1, ts, tn, tp, tf, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout: got timeout want finished"); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_ptr >= obs_q.size()) begin errors++; $display("FAIL bp_gate: got none want %h", e); end
            else begin
                if (obs_q[obs_ptr] !== e) begin errors++; $display("FAIL bp_gate: got %h want %h", obs_q[obs_ptr], e); end
                obs_ptr++;
            end
        end
        checks++; if (obs_ptr != obs_q.size()) begin errors++; $display("FAIL bp_extra: got %0d extra want 0", obs_q.size() - obs_ptr); obs_ptr = obs_q.size(); end
        checks++; if (viol_cnt - x0 != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable offers want 0", viol_cnt - x0); end
        checks++; if (valid_cnt - v0 != 8) begin errors++; $display("FAIL bp_valid_cycles: got %0d want 8", valid_cnt - v0); end
        checks++; if (tf - tn != 13) begin errors++; $display("FAIL bp_latency: got %0d want 13", tf - tn); end
        step();
    endtask

    task automatic test_multi_cycle();
        int ts, tn, tp, tf, p0, f0;
        bit to;
        logic [31:0] e;
        p0 = prep_cnt; f0 = fin_cnt;
        for (int c = 0; c < 3; c++)
            for (int a = 0; a < 2; a++) exp_q.push_back(enc(c, a));
        run_session(3, 2, -1, 0, -1, -1, ts, tn, tp, tf, to);
        checks++; if (to) begin errors++; $display("FAIL multi_timeout: got timeout want finished"); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_ptr >= obs_q.size()) begin errors++; $display("FAIL multi_gate: got none want %h", e); end
            else begin
                if (obs_q[obs_ptr] !== e) begin errors++; $display("FAIL multi_gate: got %h want %h", obs_q[obs_ptr], e); end
                obs_ptr++;
            end
        end
        checks++; if (obs_ptr != obs_q.size()) begin errors++; $display("FAIL multi_extra: got %0d extra want 0", obs_q.size() - obs_ptr); obs_ptr = obs_q.size(); end
        checks++; if (prep_cnt - p0 != 3) begin errors++; $display("FAIL multi_prep_cnt: got %0d want 3", prep_cnt - p0); end
        checks++; if (bus.cycle_idx !== C'(2)) begin errors++; $display("FAIL multi_final_idx: got %0d want 2", bus.cycle_idx); end
        step();
        checks++; if (fin_cnt - f0 != 1) begin errors++; $display("FAIL multi_fin_cnt: got %0d want 1", fin_cnt - f0); end
        checks++; if (bus.cycle_idx !== C'(2)) begin errors++; $display("FAIL multi_idx_hold: got %0d want 2", bus.cycle_idx); end
    endtask

    task automatic test_boundaries();
        int ts, tn, tp, tf, p0, v0;
        bit to;
        p0 = prep_cnt;
        run_session(0, 3, -1, 0, -1, -1, ts, tn, tp, tf, to);
        checks++; if (to) begin errors++; $display("FAIL zero_cyc_timeout: got timeout want finished"); end
        checks++; if (tf - ts != 2) begin errors++; $display("FAIL zero_cyc_latency: got %0d want 2", tf - ts); end
        checks++; if (prep_cnt - p0 != 0) begin errors++; $display("FAIL zero_cyc_prep: got %0d want 0", prep_cnt - p0); end
        step();
        p0 = prep_cnt; v0 = valid_cnt;
        run_session(2, 0, -1, 0, -1, -1, ts, tn, tp, tf, to);
        checks++; if (to) begin errors++; $display("FAIL zero_gate_timeout: got timeout want finished"); end
        checks++; if (valid_cnt - v0 != 0) begin errors++; $display("FAIL zero_gate_valid: got %0d want 0", valid_cnt - v0); end
        checks++; if (prep_cnt - p0 != 2) begin errors++; $display("FAIL zero_gate_prep: got %0d want 2", prep_cnt - p0); end
        checks++; if (obs_ptr != obs_q.size()) begin errors++; $display("FAIL zero_gate_accepts: got %0d want 0", obs_q.size() - obs_ptr); obs_ptr = obs_q.size(); end
        step();
    endtask

    task automatic test_reset_mid();
        int ts, tn, tp, tf;
        bit to;
        logic [31:0] e;
        for (int a = 0; a < 3; a++) exp_q.push_back(enc(0, a));
        for (int a = 0; a < 2; a++) exp_q.push_back(enc(1, a));
        run_session(2, 3, -1, 0, 1, 2, ts, tn, tp, tf, to);
        checks++; if (to) begin errors++; $display("FAIL rmid_timeout: got timeout want reset point"); end
        checks++; if (bus.busy !== 1'b0 || bus.g_valid !== 1'b0 || bus.prep_next_cycle !== 1'b0 || bus.finished !== 1'b0) begin
            errors++; $display("FAIL rmid_flags: got busy=%b valid=%b prep=%b fin=%b want all 0",
                               bus.busy, bus.g_valid, bus.prep_next_cycle, bus.finished); end
        checks++; if (bus.rd_addr !== '0 || bus.cycle_idx !== '0) begin
            errors++; $display("FAIL rmid_regs: got rd_addr=%0d cycle_idx=%0d want 0/0", bus.rd_addr, bus.cycle_idx); end
        for (int a = 0; a < 2; a++) exp_q.push_back(enc(0, a));
        run_session(1, 2, -1, 0, -1, -1, ts, tn, tp, tf, to);
        checks++; if (to) begin errors++; $display("FAIL rmid_restart_timeout: got timeout want finished"); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_ptr >= obs_q.size()) begin errors++; $display("FAIL rmid_gate: got none want %h", e); end
            else begin
                if (obs_q[obs_ptr] !== e) begin errors++; $display("FAIL rmid_gate: got %h want %h", obs_q[obs_ptr], e); end
                obs_ptr++;
            end
        end
        checks++; if (obs_ptr != obs_q.size()) begin errors++; $display("FAIL rmid_extra: got %0d extra want 0", obs_q.size() - obs_ptr); obs_ptr = obs_q.size(); end
        checks++; if (tf - tn != 6) begin errors++; $display("FAIL rmid_restart_latency: got %0d want 6", tf - tn); end
        step();
    endtask

`ifdef GATE_SCHED_STATS_EN
    task automatic test_stats();
        int ts, tn, tp, tf;
        bit to;
        code_tbl[0] = 4'b0110; code_tbl[1] = 4'b0001; code_tbl[2] = 4'b0110;
        run_session(1, 3, -1, 0, -1, -1, ts, tn, tp, tf, to);
        checks++; if (to) begin errors++; $display("FAIL stats_timeout: got timeout want finished"); end
        checks++; if (bus.xor_cnt !== 32'd2) begin errors++; $display("FAIL stats_xor: got %0d want 2", bus.xor_cnt); end
        checks++; if (bus.nonxor_cnt !== 32'd1) begin errors++; $display("FAIL stats_nonxor: got %0d want 1", bus.nonxor_cnt); end
        obs_ptr = obs_q.size();
        step();
        bus.start = 1'b1;
        bus.num_cycles = C'(1);
        step();
        bus.start = 1'b0;
        checks++; if (bus.xor_cnt !== '0 || bus.nonxor_cnt !== '0) begin errors++;
            $display("FAIL stats_clear: got %0d/%0d want 0/0", bus.xor_cnt, bus.nonxor_cnt); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) code_tbl[i] = 4'b0000;
        step();
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) code_tbl[i] = 4'b0000;
        bus.start = 1'b0;
        bus.num_cycles = '0;
        bus.nl_done = 1'b0;
        bus.gate_size = '0;
        bus.g_logic = '0;
        bus.g_ready = 1'b0;
        test_reset();
        test_single_cycle();
        test_backpressure();
        test_multi_cycle();
        test_boundaries();
        test_reset_mid();
`ifdef GATE_SCHED_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
